// File: rtl/nn_pkg.sv
// ============================================================================
// Module  : nn_pkg
// Brief   : Shared constants and the argmax FSM state type for the NN layers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package nn_pkg;

    localparam int NN_WIDTH      = 16;
    localparam int NN_L2_OUTPUTS = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } argmax_state_t;

endpackage : nn_pkg

`default_nettype wire

// File: rtl/layer2_argmax.sv
// ============================================================================
// Module  : layer2_argmax
// Brief   : Sequential signed argmax over the layer2 logit vector; optional
//           out_score port enabled by ARGMAX_SCORE_OUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module layer2_argmax
    import nn_pkg::*;
#(
    parameter int    OUTPUT_SIZE = NN_L2_OUTPUTS,
    parameter int    WIDTH       = NN_WIDTH,
    localparam int   IDX_W       = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OUTPUT_SIZE*WIDTH-1:0] in_logits,
    output logic                         out_valid,
    input  logic                         out_ready,
`ifdef ARGMAX_SCORE_OUT_EN
    output logic [WIDTH-1:0]             out_score,
`endif
    output logic [IDX_W-1:0]             out_class
);

    localparam logic [IDX_W-1:0] c_first_idx = IDX_W'((OUTPUT_SIZE > 1) ? 1 : 0);
    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(OUTPUT_SIZE - 1);

    argmax_state_t                r_state;
    argmax_state_t                w_state_next;
    logic [OUTPUT_SIZE*WIDTH-1:0] r_buf;
    logic signed [WIDTH-1:0]      r_best_val;
    logic [IDX_W-1:0]             r_best_idx;
    logic [IDX_W-1:0]             r_idx;
    logic                         r_out_valid;
    logic [IDX_W-1:0]             r_out_class;

    logic                         w_accept;
    logic                         w_last;
    logic                         w_better;
    logic signed [WIDTH-1:0]      w_cand;
    logic signed [WIDTH-1:0]      w_new_val;
    logic [IDX_W-1:0]             w_new_idx;

    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_idx == c_last_idx);
    assign w_cand    = r_buf[int'(r_idx)*WIDTH +: WIDTH];
    // Strict greater-than keeps the lowest index on ties.
    assign w_better  = (w_cand > r_best_val);
    assign w_new_val = w_better ? w_cand : r_best_val;
    assign w_new_idx = w_better ? r_idx  : r_best_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = !rst;
                if (w_accept) begin
                    w_state_next = (OUTPUT_SIZE == 1) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (r_out_valid && out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf       <= '0;
            r_best_val  <= '0;
            r_best_idx  <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_class <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_buf      <= in_logits;
                        r_best_val <= in_logits[WIDTH-1:0];
                        r_best_idx <= '0;
                        r_idx      <= c_first_idx;
                    end
                end
                SCAN: begin
                    r_best_val <= w_new_val;
                    r_best_idx <= w_new_idx;
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_out_class <= w_new_idx;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    // Single-logit builds enter DONE straight from IDLE and publish here.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_class <= r_best_idx;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ARGMAX_SCORE_OUT_EN
    logic [WIDTH-1:0] r_out_score;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_score <= '0;
        end else if (r_state == SCAN && w_last) begin
            r_out_score <= w_new_val;
        end else if (r_state == DONE && !r_out_valid) begin
            r_out_score <= r_best_val;
        end
    end

    assign out_score = r_out_score;
`endif

    assign out_valid = r_out_valid;
    assign out_class = r_out_class;

endmodule : layer2_argmax

`default_nettype wire

// File: tb/tb_layer2_argmax.sv
// ============================================================================
// Module  : tb_layer2_argmax
// Brief   : Directed self-checking bench for layer2_argmax (5-logit and
//           1-logit instances); score checks active with ARGMAX_SCORE_OUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_layer2_argmax;

    localparam int OS = 5;
    localparam int W  = 16;
    localparam int VW = OS * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] in_logits = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2:0]    out_class;

    logic          in_valid1 = 1'b0;
    logic          in_ready1;
    logic [W-1:0]  in_logits1 = '0;
    logic          out_valid1;
    logic          out_ready1 = 1'b0;
    logic [0:0]    out_class1;

`ifdef ARGMAX_SCORE_OUT_EN
    logic [W-1:0]  out_score;
    logic [W-1:0]  out_score1;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    layer2_argmax #(.OUTPUT_SIZE(OS), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_logits (in_logits),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef ARGMAX_SCORE_OUT_EN
        .out_score (out_score),
`endif
        .out_class (out_class)
    );

    layer2_argmax #(.OUTPUT_SIZE(1), .WIDTH(W)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_logits (in_logits1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
`ifdef ARGMAX_SCORE_OUT_EN
        .out_score (out_score1),
`endif
        .out_class (out_class1)
    );

    function automatic logic [VW-1:0] pack5(input int a0, input int a1, input int a2,
                                            input int a3, input int a4);
        return {W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    // Present a vector for one edge; returns at the negedge after acceptance.
    task automatic do_accept(input logic [VW-1:0] v);
        @(negedge clk);
        in_valid  = 1'b1;
        in_logits = v;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_class !== 3'd0) $display("FAIL reset_out_class got %0d want 0", out_class); else n_pass++;
`ifdef ARGMAX_SCORE_OUT_EN
        n_total++; if (out_score !== 16'h0000) $display("FAIL reset_out_score got %h want 0000", out_score); else n_pass++;
`endif
        rst = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_tie_break();
        int cyc;
        do_accept(pack5(3, -2, 10, 7, 10));
        wait_valid(cyc);
        n_total++; if (cyc != 4) $display("FAIL tie_latency got %0d want 4", cyc); else n_pass++;
        n_total++; if (out_class !== 3'd2) $display("FAIL tie_class got %0d want 2", out_class); else n_pass++;
`ifdef ARGMAX_SCORE_OUT_EN
        n_total++; if (out_score !== 16'd10) $display("FAIL tie_score got %h want 000a", out_score); else n_pass++;
`endif
        handshake();
        n_total++; if (out_valid !== 1'b0) $display("FAIL tie_drop_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL tie_in_ready got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_signedness();
        int cyc;
        do_accept(pack5(-5, -1, -8, -3, -9));
        wait_valid(cyc);
        n_total++; if (out_class !== 3'd1) $display("FAIL neg_class got %0d want 1", out_class); else n_pass++;
`ifdef ARGMAX_SCORE_OUT_EN
        n_total++; if (out_score !== 16'hFFFF) $display("FAIL neg_score got %h want ffff", out_score); else n_pass++;
`endif
        handshake();
        do_accept(pack5(5, -1, -8, -3, -9));
        wait_valid(cyc);
        n_total++; if (out_class !== 3'd0) $display("FAIL mixed_class got %0d want 0", out_class); else n_pass++;
`ifdef ARGMAX_SCORE_OUT_EN
        n_total++; if (out_score !== 16'd5) $display("FAIL mixed_score got %h want 0005", out_score); else n_pass++;
`endif
        handshake();
    endtask

    task automatic test_backpressure();
        int cyc;
        int extra;
        do_accept(pack5(1, 9, 2, 3, 4));
        wait_valid(cyc);
        n_total++; if (cyc != 4) $display("FAIL bp_latency got %0d want 4", cyc); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                in_valid  = 1'b1;
                in_logits = pack5(50, 60, 70, 80, 90);
            end
            if (i == 4) in_valid = 1'b0;
            n_total++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d] got %b want 1", i, out_valid); else n_pass++;
            n_total++; if (out_class !== 3'd1) $display("FAIL bp_hold_class[%0d] got %0d want 1", i, out_class); else n_pass++;
            n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); else n_pass++;
        end
        handshake();
        n_total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b want 1", in_ready); else n_pass++;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid === 1'b1) extra++;
        end
        n_total++; if (extra != 0) $display("FAIL bp_no_capture got %0d valid cycles want 0", extra); else n_pass++;
    endtask

    task automatic test_isolation();
        int cyc;
        do_accept(pack5(-100, 200, -300, 150, 199));
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 30) begin
            in_logits = VW'({$urandom(), $urandom(), $urandom()});
            @(negedge clk);
            cyc++;
        end
        n_total++; if (cyc != 4) $display("FAIL iso_latency got %0d want 4", cyc); else n_pass++;
        n_total++; if (out_class !== 3'd1) $display("FAIL iso_class got %0d want 1", out_class); else n_pass++;
`ifdef ARGMAX_SCORE_OUT_EN
        n_total++; if (out_score !== 16'd200) $display("FAIL iso_score got %h want 00c8", out_score); else n_pass++;
`endif
        handshake();
    endtask

    task automatic test_back_to_back();
        int       v_cyc [2];
        logic [2:0] v_cls [2];
        int       nv;
        nv = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_logits = pack5(0, 0, 0, 0, 9);
        @(posedge clk);
        @(negedge clk);
        in_logits = pack5(8, 1, 1, 1, 1);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 6) in_valid = 1'b0;
            if (out_valid === 1'b1) begin
                if (nv < 2) begin
                    v_cyc[nv] = c;
                    v_cls[nv] = out_class;
                end
                nv++;
            end
        end
        out_ready = 1'b0;
        n_total++; if (nv != 2) $display("FAIL b2b_count got %0d want 2", nv); else n_pass++;
        if (nv >= 2) begin
            n_total++; if (v_cyc[0] != 4) $display("FAIL b2b_first_cycle got %0d want 4", v_cyc[0]); else n_pass++;
            n_total++; if (v_cls[0] !== 3'd4) $display("FAIL b2b_first_class got %0d want 4", v_cls[0]); else n_pass++;
            n_total++; if (v_cyc[1] != 10) $display("FAIL b2b_second_cycle got %0d want 10", v_cyc[1]); else n_pass++;
            n_total++; if (v_cls[1] !== 3'd0) $display("FAIL b2b_second_class got %0d want 0", v_cls[1]); else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        int cyc;
        int extra;
        do_accept(pack5(7, 1, 1, 1, 1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL rst_mid_in_ready got %b want 0", in_ready); else n_pass++;
        @(negedge clk);
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL rst_mid_in_ready_held got %b want 0", in_ready); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_mid_release got %b want 1", in_ready); else n_pass++;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid === 1'b1) extra++;
        end
        n_total++; if (extra != 0) $display("FAIL rst_mid_partial got %0d valid cycles want 0", extra); else n_pass++;
        do_accept(pack5(1, 2, 3, 4, 5));
        wait_valid(cyc);
        n_total++; if (cyc != 4) $display("FAIL rst_new_latency got %0d want 4", cyc); else n_pass++;
        n_total++; if (out_class !== 3'd4) $display("FAIL rst_new_class got %0d want 4", out_class); else n_pass++;
`ifdef ARGMAX_SCORE_OUT_EN
        n_total++; if (out_score !== 16'd5) $display("FAIL rst_new_score got %h want 0005", out_score); else n_pass++;
`endif
        handshake();
    endtask

    task automatic test_single_logit();
        @(negedge clk);
        in_valid1  = 1'b1;
        in_logits1 = 16'hFFF9;
        @(posedge clk);
        @(negedge clk);
        in_valid1  = 1'b0;
        in_logits1 = 16'h1234;
        n_total++; if (out_valid1 !== 1'b0) $display("FAIL one_early_valid got %b want 0", out_valid1); else n_pass++;
        @(negedge clk);
        n_total++; if (out_valid1 !== 1'b1) $display("FAIL one_valid got %b want 1", out_valid1); else n_pass++;
        n_total++; if (out_class1 !== 1'b0) $display("FAIL one_class got %0d want 0", out_class1); else n_pass++;
`ifdef ARGMAX_SCORE_OUT_EN
        n_total++; if (out_score1 !== 16'hFFF9) $display("FAIL one_score got %h want fff9", out_score1); else n_pass++;
`endif
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        n_total++; if (out_valid1 !== 1'b0) $display("FAIL one_drop_valid got %b want 0", out_valid1); else n_pass++;
        n_total++; if (in_ready1 !== 1'b1) $display("FAIL one_in_ready got %b want 1", in_ready1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_tie_break();
        test_signedness();
        test_backpressure();
        test_isolation();
        test_back_to_back();
        test_reset_mid_scan();
        test_single_logit();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule : tb_layer2_argmax

`default_nettype wire
